// File: rtl/mux_nto1_pipe.sv
// N-way, W-bit selector with a registered valid/ready output stage and a
// one-entry skid buffer. Each beat carries its select and an out-of-range flag.
module mux_nto1_pipe #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned CNT_W  = 8,
  localparam int unsigned SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic [CNT_W-1:0]        beat_cnt
);

  typedef struct packed {
    logic             err;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
  } beat_t;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             in_ready_q;
  logic             out_valid_q;
  beat_t            out_q;
  beat_t            skid_q;
  beat_t            beat_c;
  logic [CNT_W-1:0] cnt_q;
  logic             in_acc;
  logic             out_acc;
  logic             load_out;
  logic             load_skid;
  logic             out_from_skid;

  assign in_acc  = in_valid & in_ready_q;
  assign out_acc = out_valid_q & out_ready;

  // Form the beat from the current select; out-of-range selects carry zero data.
  always_comb begin
    beat_c      = '0;
    beat_c.sel  = sel;
    if (32'(sel) >= NUM_IN) begin
      beat_c.err = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NUM_IN; k++) begin
        if (sel == SEL_W'(k)) begin
          beat_c.data = in_data[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Next-state and buffer-load decisions.
  always_comb begin
    state_nxt     = state;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (in_acc) begin
          state_nxt = ONE;
          load_out  = 1'b1;
        end
      end
      ONE: begin
        if (in_acc && out_acc) begin
          load_out = 1'b1;
        end else if (in_acc) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (out_acc) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_acc) begin
          state_nxt     = ONE;
          load_out      = 1'b1;
          out_from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // State register; handshake flags are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt != FULL);
      out_valid_q <= (state_nxt != EMPTY);
    end
  end

  // Output register, skid entry and completed-transfer counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (load_out) begin
        out_q <= out_from_skid ? skid_q : beat_c;
      end
      if (load_skid) begin
        skid_q <= beat_c;
      end
      if (out_acc) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q.data;
  assign out_sel   = out_q.sel;
  assign out_err   = out_q.err;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Bench for mux_nto1_pipe: directed scenarios plus randomized traffic checked
// by a queue-based scoreboard; a second instance covers out-of-range and wrap.
module tb_mux_nto1_pipe;

  logic clk;
  logic rst;

  // Instance A: NUM_IN=4, WIDTH=5, CNT_W=8
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [1:0]  a_sel, a_out_sel;
  logic [19:0] a_in_data;
  logic [4:0]  a_out_data;
  logic [7:0]  a_beat_cnt;

  // Instance B: NUM_IN=3, WIDTH=5, CNT_W=2
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [1:0]  b_sel, b_out_sel;
  logic [14:0] b_in_data;
  logic [4:0]  b_out_data;
  logic [1:0]  b_beat_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_cnt;
  logic       stall;
  logic [15:0] prev_out;

  mux_nto1_pipe #(.NUM_IN(4), .WIDTH(5), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .sel(a_sel), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_sel(a_out_sel), .out_err(a_out_err), .beat_cnt(a_beat_cnt)
  );

  mux_nto1_pipe #(.NUM_IN(3), .WIDTH(5), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .sel(b_sel), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_sel(b_out_sel), .out_err(b_out_err), .beat_cnt(b_beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference beat for instance A: {err, sel, data}.
  function automatic logic [7:0] model_a(input logic [1:0] s, input logic [19:0] d);
    logic [4:0] data;
    logic       err;
    if (int'(s) < 4) begin
      data = 5'((d >> (int'(s) * 5)) & 20'h1F);
      err  = 1'b0;
    end else begin
      data = 5'd0;
      err  = 1'b1;
    end
    return {err, s, data};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [1:0] s);
    logic ok;
    ok = 1'b0;
    a_sel = s;
    a_in_valid = 1'b1;
    for (int n = 0; n < 8 && !ok; n++) begin
      ok = a_in_ready;
      cyc();
    end
    a_in_valid = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
  endtask

  // Input sampler: record each accepted beat of instance A.
  always @(negedge clk) begin
    if (!rst && a_in_valid && a_in_ready) begin
      exp_q.push_back(model_a(a_sel, a_in_data));
    end
  end

  // Output monitor: compare transferred beats, counter and stall stability.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_cnt = 8'd0;
      stall   = 1'b0;
    end else begin
      if (stall) begin
        check("stall_hold", 32'({a_out_valid, a_out_err, a_out_sel, a_out_data}),
              32'(prev_out));
      end
      check("beat_cnt", 32'(a_beat_cnt), 32'(exp_cnt));
      if (a_out_valid && a_out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'({a_out_err, a_out_sel, a_out_data}), 32'hFFFF);
        end else begin
          check("beat", 32'({a_out_err, a_out_sel, a_out_data}), 32'(exp_q.pop_front()));
        end
        exp_cnt = exp_cnt + 8'd1;
      end
      stall    = a_out_valid && !a_out_ready;
      prev_out = {8'd0, a_out_valid, a_out_err, a_out_sel, a_out_data};
    end
  end

  initial begin
    logic [4:0] stream_exp [4];
    logic [1:0] b_cnt_exp [5];
    logic [1:0] b_sels [5];
    int budget;
    stream_exp = '{5'h03, 5'h0A, 5'h15, 5'h1F};
    b_cnt_exp  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    b_sels     = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd0};

    rst = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_sel = 2'd0;
    a_in_data = {5'h1F, 5'h15, 5'h0A, 5'h03};
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_sel = 2'd0;
    b_in_data = {5'h15, 5'h0A, 5'h03};

    // Reset
    cyc(); cyc();
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_data", 32'(a_out_data), 32'd0);
    check("rst_in_ready", 32'(a_in_ready), 32'd0);
    check("rst_beat_cnt", 32'(a_beat_cnt), 32'd0);
    rst = 1'b0;
    cyc();
    check("post_rst_in_ready", 32'(a_in_ready), 32'd1);

    // Streaming at full rate
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s);
      cyc();
      check("stream_valid", 32'(a_out_valid), 32'd1);
      check("stream_data", 32'(a_out_data), 32'(stream_exp[s]));
    end
    a_in_valid = 1'b0;
    cyc();
    check("stream_cnt", 32'(a_beat_cnt), 32'd4);
    check("stream_idle", 32'(a_out_valid), 32'd0);

    // Backpressure into the skid entry
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_sel = 2'd1;
    cyc();
    a_sel = 2'd2;
    cyc();
    a_in_valid = 1'b0;
    check("full_in_ready", 32'(a_in_ready), 32'd0);
    check("full_data", 32'(a_out_data), 32'h0A);
    cyc();
    check("full_hold_data", 32'(a_out_data), 32'h0A);
    check("full_hold_ready", 32'(a_in_ready), 32'd0);
    a_out_ready = 1'b1;
    cyc();
    check("drain_second", 32'(a_out_data), 32'h15);
    check("drain_in_ready", 32'(a_in_ready), 32'd1);
    cyc();
    check("bp_cnt", 32'(a_beat_cnt), 32'd6);
    check("bp_idle", 32'(a_out_valid), 32'd0);

    // Reset while full
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_sel = 2'd0;
    cyc();
    a_sel = 2'd3;
    cyc();
    a_in_valid = 1'b0;
    check("pre_rst_full", 32'(a_in_ready), 32'd0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("midrst_valid", 32'(a_out_valid), 32'd0);
    check("midrst_cnt", 32'(a_beat_cnt), 32'd0);
    send_a(2'd0);
    check("after_rst_valid", 32'(a_out_valid), 32'd1);
    check("after_rst_beat", 32'({a_out_err, a_out_sel, a_out_data}), 32'h003);
    a_out_ready = 1'b1;
    cyc();
    check("after_rst_cnt", 32'(a_beat_cnt), 32'd1);
    check("after_rst_idle", 32'(a_out_valid), 32'd0);

    // Out-of-range select and counter wrap on the 3-input instance
    b_out_ready = 1'b1;
    b_in_valid  = 1'b1;
    b_sel = b_sels[0];
    cyc();
    check("oor_data", 32'(b_out_data), 32'd0);
    check("oor_err", 32'(b_out_err), 32'd1);
    check("oor_sel", 32'(b_out_sel), 32'd3);
    for (int i = 1; i < 5; i++) begin
      b_sel = b_sels[i];
      cyc();
      check("wrap_cnt", 32'(b_beat_cnt), 32'(b_cnt_exp[i-1]));
      if (i == 1) begin
        check("inrange_err", 32'(b_out_err), 32'd0);
        check("inrange_data", 32'(b_out_data), 32'h15);
      end
    end
    b_in_valid = 1'b0;
    cyc();
    check("wrap_cnt", 32'(b_beat_cnt), 32'(b_cnt_exp[4]));

    // Randomized traffic on instance A
    for (int i = 0; i < 3000; i++) begin
      a_in_valid  = 1'($urandom_range(0, 1));
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_sel       = 2'($urandom_range(0, 3));
      a_in_data   = 20'($urandom);
      cyc();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    budget = 0;
    while (a_out_valid && budget < 10) begin
      cyc();
      budget++;
    end
    cyc();
    check("drain_done", 32'(a_out_valid), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
